qam_mapper: RTL and testbench
=============================

Name: qam_mapper

Overview:
- Downstream neighbour of the interleaver. Consumes its serial interleaved bit stream (one bit per valid cycle).
- Groups bits into N_BPSC-bit words: 1 for BPSK, 2 for QPSK, 4 for 16-QAM, 6 for 64-QAM.
- Emits one Gray-mapped, K_MOD-normalised I/Q constellation point per group, per 802.11a Figure 107.
- Tags each point with its data-subcarrier index (0..47), so pilot insertion / IFFT loading can follow directly.

Parameters:
- OUT_W, 16, I/Q sample width; signed fixed-point Q2.14. Only 16 is supported; the constants below assume it.
- N_SD, 48, data subcarriers per OFDM symbol; sets the wrap point of the subcarrier index.

Ports:
- clock  in  1  rising-edge system clock.
- reset  in  1  asynchronous, active-low reset.
- inputData  in  1  serial interleaved bit; the first-received bit is b0.
- inputValid  in  1  inputData is valid this cycle.
- mode  in  2  00 BPSK, 01 QPSK, 10 16-QAM, 11 64-QAM.
- clear  in  1  synchronous abort: discards any partial group and zeroes the subcarrier index.
- outI  out  OUT_W  in-phase sample, signed.
- outQ  out  OUT_W  quadrature sample, signed.
- outValid  out  1  one-cycle strobe; outI, outQ and scIndex are valid.
- scIndex  out  6  data-subcarrier index of the current point, 0..N_SD-1.
- symEnd  out  1  asserted together with outValid when scIndex == N_SD-1.

Behaviour:
- Reset (reset low, asynchronous): all outputs 0; bit counter 0; shift register 0; subcarrier index 0; latched mode 00.
- Mode latching: mode is sampled on the accepted bit that starts a group (bit counter == 0). A mode change mid-group has no effect until the next group starts.
- Bit accept: on each cycle with inputValid=1, the bit is shifted into the group register in arrival order and the bit counter increments.
- Gaps: inputValid=0 mid-group holds all state; gaps of any length are legal.
- Group completion: when the accepted bit is number N_BPSC of the group:
  - the counter returns to 0;
  - the point is computed and registered;
  - outValid is high on the next cycle, so latency is 1 cycle from the last bit of the group.
- outValid is high for exactly 1 cycle per group. Otherwise outI/outQ hold their last value and outValid=0.
- Back-to-back input: BPSK with continuous input gives outValid every cycle.
- Level mapping (Gray):
  - BPSK: b0 0→-1, 1→+1; Q=0.
  - QPSK: I from b0, Q from b1; each 0→-1, 1→+1.
  - 16-QAM: I from b0b1, Q from b2b3; 00→-3, 01→-1, 11→+1, 10→+3.
  - 64-QAM: I from b0b1b2, Q from b3b4b5; 000→-7, 001→-5, 011→-3, 010→-1, 110→+1, 111→+3, 101→+5, 100→+7.
- Scaling: output = level × K, with K as Q2.14 constants: BPSK 16384, QPSK 11585, 16-QAM 5181, 64-QAM 2528.
  - Worst case 7×2528 = 17696, which fits in signed 16 bits; no saturation logic is needed.
  - The multiply by the small odd level is done with a constant LUT of the level products, no DSP.
- Subcarrier index:
  - scIndex output equals the internal index at the time of the point.
  - The internal index increments after each emitted point and wraps N_SD-1 → 0.
  - symEnd is asserted with the point at index 47.
- clear: same cycle as an accepted bit → clear wins and the bit is dropped. In the cycle after clear, outValid=0 even if a group completed in the clear cycle.
- Reset mid-group: the partial group is lost; there is no flush.

Decomposition:
- Shared package (phy_pkg), consumed by this block, the interleaver and later stages:
  - mode encodings;
  - N_BPSC per mode (1, 2, 4, 6);
  - N_CBPS per mode (48, 96, 192, 288);
  - K_MOD Q2.14 constants;
  - N_SD=48.
- Sub-module qam_level_lut: purely combinational; (mode, group bits) → (signed I level×K, signed Q level×K). The top level holds the counter, shift register, index and output registers.

Test Plan:
- BPSK, continuous bits 1,0,1 after reset release → outValid on 3 consecutive cycles, each 1 cycle after its bit; outI = +16384, -16384, +16384; outQ=0; scIndex 0, 1, 2.
- QPSK, bits b0=0, b1=1 → single strobe with outI=-11585, outQ=+11585; no strobe after the first bit.
- 16-QAM, bits 1,0,0,1 with 3 idle cycles inserted after bit 2 → one strobe 1 cycle after bit 4; outI=+3×5181=15543; outQ=-1×5181=-5181.
- 64-QAM, bits 1,0,0,0,0,0 → outI=+17696, outQ=-17696. Bits 0,1,0,1,1,0 → outI=-2528, outQ=+2528.
- BPSK, 96 continuous bits → scIndex cycles 0..47 twice; symEnd high on exactly 2 strobes (index 47); index 0 follows 47.
- 16-QAM, 2 bits then clear, mode switched to QPSK, then bits 1,1 → exactly one strobe, outI=outQ=+11585, scIndex=0. Separately: assert reset low mid-group → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/phy_pkg.sv
// Definitions shared by the 802.11a baseband stages: modulation encodings, per-mode
// bit counts and K_MOD normalisation constants in Q2.14.
package phy_pkg;

    typedef enum logic [1:0] {
        ModBpsk  = 2'b00,
        ModQpsk  = 2'b01,
        Mod16Qam = 2'b10,
        Mod64Qam = 2'b11
    } mod_e;

    localparam int unsigned NSd = 48;

    localparam logic signed [15:0] KModBpsk  = 16'sd16384;
    localparam logic signed [15:0] KModQpsk  = 16'sd11585;
    localparam logic signed [15:0] KMod16Qam = 16'sd5181;
    localparam logic signed [15:0] KMod64Qam = 16'sd2528;

    function automatic logic [2:0] n_bpsc(input mod_e m);
        logic [2:0] n;
        case (m)
            ModBpsk:  n = 3'd1;
            ModQpsk:  n = 3'd2;
            Mod16Qam: n = 3'd4;
            default:  n = 3'd6;
        endcase
        return n;
    endfunction

    function automatic logic [8:0] n_cbps(input mod_e m);
        logic [8:0] n;
        case (m)
            ModBpsk:  n = 9'd48;
            ModQpsk:  n = 9'd96;
            Mod16Qam: n = 9'd192;
            default:  n = 9'd288;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/qam_level_lut.sv
// Combinational Gray-coded constellation lookup returning level x K_MOD for I and Q.
// Group bits arrive MSB-first: bits_i[N_BPSC-1] is b0, bits_i[0] is the last bit.
module qam_level_lut
    import phy_pkg::*;
(
    input  mod_e               mode_i,
    input  logic [5:0]         bits_i,
    output logic signed [15:0] i_o,
    output logic signed [15:0] q_o
);

    function automatic logic signed [15:0] lvl16(input logic [1:0] g);
        logic signed [15:0] v;
        case (g)
            2'b00:   v = -(KMod16Qam * 16'sd3);
            2'b01:   v = -KMod16Qam;
            2'b11:   v = KMod16Qam;
            default: v = KMod16Qam * 16'sd3;
        endcase
        return v;
    endfunction

    function automatic logic signed [15:0] lvl64(input logic [2:0] g);
        logic signed [15:0] v;
        case (g)
            3'b000:  v = -(KMod64Qam * 16'sd7);
            3'b001:  v = -(KMod64Qam * 16'sd5);
            3'b011:  v = -(KMod64Qam * 16'sd3);
            3'b010:  v = -KMod64Qam;
            3'b110:  v = KMod64Qam;
            3'b111:  v = KMod64Qam * 16'sd3;
            3'b101:  v = KMod64Qam * 16'sd5;
            default: v = KMod64Qam * 16'sd7;
        endcase
        return v;
    endfunction

    always_comb begin
        i_o = '0;
        q_o = '0;
        unique case (mode_i)
            ModBpsk: begin
                i_o = bits_i[0] ? KModBpsk : -KModBpsk;
            end
            ModQpsk: begin
                i_o = bits_i[1] ? KModQpsk : -KModQpsk;
                q_o = bits_i[0] ? KModQpsk : -KModQpsk;
            end
            Mod16Qam: begin
                i_o = lvl16(bits_i[3:2]);
                q_o = lvl16(bits_i[1:0]);
            end
            Mod64Qam: begin
                i_o = lvl64(bits_i[5:3]);
                q_o = lvl64(bits_i[2:0]);
            end
        endcase
    end

endmodule

// File: rtl/qam_mapper.sv
// Groups the serial interleaved bit stream into N_BPSC-bit words and emits one
// normalised I/Q point per word, tagged with its data-subcarrier index.
module qam_mapper
    import phy_pkg::*;
#(
    parameter int unsigned OUT_W = 16,
    parameter int unsigned N_SD  = NSd
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    inputData,
    input  logic                    inputValid,
    input  logic [1:0]              mode,
    input  logic                    clear,
    output logic signed [OUT_W-1:0] outI,
    output logic signed [OUT_W-1:0] outQ,
    output logic                    outValid,
    output logic [5:0]              scIndex,
    output logic                    symEnd
);

    logic [2:0]              cnt_q, cnt_d;
    logic [4:0]              shreg_q, shreg_d;
    mod_e                    mode_q, mode_d;
    logic [5:0]              idx_q, idx_d;
    logic signed [OUT_W-1:0] i_q, i_d, q_q, q_d;
    logic                    valid_q, valid_d;
    logic [5:0]              sc_q, sc_d;
    logic                    sym_q, sym_d;

    logic                    accept;
    logic                    done;
    mod_e                    eff_mode;
    logic [5:0]              group;
    logic signed [15:0]      lut_i, lut_q;

    // Mode is only sampled by the bit that opens a group.
    assign eff_mode = (cnt_q == 3'd0) ? mod_e'(mode) : mode_q;
    assign accept   = inputValid & ~clear;
    assign done     = accept && ((cnt_q + 3'd1) == n_bpsc(eff_mode));
    assign group    = {shreg_q, inputData};

    qam_level_lut u_lut (
        .mode_i (eff_mode),
        .bits_i (group),
        .i_o    (lut_i),
        .q_o    (lut_q)
    );

    always_comb begin
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        i_d     = i_q;
        q_d     = q_q;
        valid_d = 1'b0;
        sc_d    = sc_q;
        sym_d   = 1'b0;
        if (clear) begin
            cnt_d   = '0;
            shreg_d = '0;
            idx_d   = '0;
        end else if (accept) begin
            mode_d  = eff_mode;
            shreg_d = {shreg_q[3:0], inputData};
            if (done) begin
                cnt_d   = '0;
                i_d     = lut_i;
                q_d     = lut_q;
                valid_d = 1'b1;
                sc_d    = idx_q;
                sym_d   = (idx_q == 6'(N_SD - 1));
                idx_d   = (idx_q == 6'(N_SD - 1)) ? 6'd0 : idx_q + 6'd1;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            shreg_q <= '0;
            mode_q  <= ModBpsk;
            idx_q   <= '0;
            i_q     <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            sc_q    <= '0;
            sym_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            i_q     <= i_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            sc_q    <= sc_d;
            sym_q   <= sym_d;
        end
    end

    assign outI     = i_q;
    assign outQ     = q_q;
    assign outValid = valid_q;
    assign scIndex  = sc_q;
    assign symEnd   = sym_q;

endmodule

// File: tb/tb_qam_mapper.sv
// Directed bench for qam_mapper: expected points come from a Gray-decode model and are
// queued when the last bit of a group is driven, then checked when outValid strobes.
module tb_qam_mapper;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              inputData = 1'b0;
    logic              inputValid = 1'b0;
    logic              clear = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic signed [15:0] outI, outQ;
    logic              outValid;
    logic [5:0]        scIndex;
    logic              symEnd;

    typedef struct {
        int i;
        int q;
        int sc;
        int sym;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int idx_m     = 0;
    int sym_exp   = 0;
    int sym_seen  = 0;
    int step      = 0;

    qam_mapper dut (
        .clock      (clock),
        .reset      (reset),
        .inputData  (inputData),
        .inputValid (inputValid),
        .mode       (mode),
        .clear      (clear),
        .outI       (outI),
        .outQ       (outQ),
        .outValid   (outValid),
        .scIndex    (scIndex),
        .symEnd     (symEnd)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp_v);
        n_asserts++;
        assert (got === exp_v) else begin
            n_fail++;
            $error("FAIL %s step=%0d got %0d exp %0d", name, step, got, exp_v);
        end
    endtask

    function automatic int kmod(input logic [1:0] m);
        case (m)
            2'b00:   return 16384;
            2'b01:   return 11585;
            2'b10:   return 5181;
            default: return 2528;
        endcase
    endfunction

    function automatic int nbits(input logic [1:0] m);
        case (m)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 6;
        endcase
    endfunction

    // Gray-decode n bits (first-received is MSB) into an odd level -(2^n-1)..+(2^n-1).
    function automatic int axis(input logic [5:0] b, input int first, input int n);
        int bin = 0;
        int acc = 0;
        for (int k = 0; k < n; k++) begin
            acc = acc ^ int'(b[first + k]);
            bin = bin * 2 + acc;
        end
        return 2 * bin - ((1 << n) - 1);
    endfunction

    task automatic push(input logic [1:0] m, input logic [5:0] b);
        exp_t e;
        int k = kmod(m);
        case (m)
            2'b00: begin e.i = axis(b, 0, 1) * k; e.q = 0; end
            2'b01: begin e.i = axis(b, 0, 1) * k; e.q = axis(b, 1, 1) * k; end
            2'b10: begin e.i = axis(b, 0, 2) * k; e.q = axis(b, 2, 2) * k; end
            default: begin e.i = axis(b, 0, 3) * k; e.q = axis(b, 3, 3) * k; end
        endcase
        e.sc  = idx_m;
        e.sym = (idx_m == 47) ? 1 : 0;
        e.cyc = cyc + 1;
        sym_exp += e.sym;
        idx_m = (idx_m == 47) ? 0 : idx_m + 1;
        sb.push_back(e);
    endtask

    task automatic drive(input logic b, input logic v, input logic c, input logic [1:0] m);
        @(negedge clock);
        inputData  = b;
        inputValid = v;
        clear      = c;
        mode       = m;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, mode);
    endtask

    // bits[0] is b0; mode toggles after the first bit to prove it is latched per group.
    task automatic send_group(input logic [1:0] m, input logic [5:0] bits,
                              input int gap_at, input int gap_len);
        int n = nbits(m);
        for (int k = 0; k < n; k++) begin
            drive(bits[k], 1'b1, 1'b0, (k == 0) ? m : ~m);
            if (k == n - 1) push(m, bits);
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) drive(1'b0, 1'b0, 1'b0, ~m);
            end
        end
    endtask

    always @(negedge clock) begin
        if (reset && outValid) begin
            exp_t e;
            n_asserts++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL strobe step=%0d got unexpected outValid exp none", step);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("outI", int'(outI), e.i);
                chk("outQ", int'(outQ), e.q);
                chk("scIndex", int'(scIndex), e.sc);
                chk("symEnd", int'(symEnd), e.sym);
                chk("latency", cyc, e.cyc);
            end
            if (symEnd) sym_seen++;
        end
    end

    initial begin
        #1;
        chk("rst outI", int'(outI), 0);
        chk("rst outQ", int'(outQ), 0);
        chk("rst outValid", int'(outValid), 0);
        chk("rst scIndex", int'(scIndex), 0);
        chk("rst symEnd", int'(symEnd), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        step = 1;  // BPSK back-to-back
        send_group(2'b00, 6'b000001, -1, 0);
        send_group(2'b00, 6'b000000, -1, 0);
        send_group(2'b00, 6'b000001, -1, 0);
        idle(2);

        step = 2;  // QPSK with a gap after b0
        send_group(2'b01, 6'b000010, 0, 2);
        idle(2);

        step = 3;  // 16-QAM 1,0,0,1 with 3 idle cycles after bit 2
        send_group(2'b10, 6'b001001, 1, 3);
        idle(2);

        step = 4;  // 64-QAM corner and inner points
        send_group(2'b11, 6'b000001, -1, 0);
        send_group(2'b11, 6'b011010, 2, 1);
        idle(2);

        step = 5;  // 96 BPSK bits from a zeroed index
        drive(1'b0, 1'b0, 1'b1, 2'b00);
        idx_m = 0;
        for (int k = 0; k < 96; k++) send_group(2'b00, 6'($urandom_range(1)), -1, 0);
        idle(2);

        step = 6;  // clear discards a partial 16-QAM group, then QPSK 1,1
        drive(1'b1, 1'b1, 1'b0, 2'b10);
        drive(1'b0, 1'b1, 1'b0, 2'b10);
        drive(1'b1, 1'b1, 1'b1, 2'b10);
        idx_m = 0;
        send_group(2'b01, 6'b000011, -1, 0);
        idle(2);

        step = 7;  // clear in the cycle that would complete a QPSK group
        drive(1'b1, 1'b1, 1'b0, 2'b01);
        drive(1'b1, 1'b1, 1'b1, 2'b01);
        idx_m = 0;
        idle(3);

        step = 8;  // asynchronous reset mid-group
        send_group(2'b11, 6'b000001, -1, 0);
        idle(2);
        drive(1'b1, 1'b1, 1'b0, 2'b11);
        drive(1'b0, 1'b1, 1'b0, 2'b11);
        @(negedge clock);
        inputValid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst outI", int'(outI), 0);
        chk("arst outQ", int'(outQ), 0);
        chk("arst outValid", int'(outValid), 0);
        chk("arst scIndex", int'(scIndex), 0);
        chk("arst symEnd", int'(symEnd), 0);
        idx_m = 0;
        @(negedge clock);
        reset = 1'b1;
        send_group(2'b00, 6'b000001, -1, 0);
        idle(4);

        step = 9;
        chk("pending points", sb.size(), 0);
        chk("symEnd count", sym_seen, sym_exp);
        chk("symEnd expected", sym_exp, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
